// File: rtl/fence_sequencer.sv
// fence_sequencer: orders FENCE / FENCE.I / SFENCE.VMA side effects after a pipeline flush.
// Ports: IN_req/IN_kind/OUT_ready accept a uop; IN_sqEmpty/IN_memBusy give drain status;
// OUT_icFlushReq/IN_icFlushAck and OUT_tlbFlushReq/IN_tlbFlushAck run the flush handshakes;
// OUT_disableIFetch holds fetch off; OUT_done and OUT_timeout are single-cycle completion pulses.
module fence_sequencer #(
    parameter int TIMEOUT_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       IN_req,
    input  logic [1:0] IN_kind,
    output logic       OUT_ready,
    input  logic       IN_sqEmpty,
    input  logic       IN_memBusy,
    output logic       OUT_icFlushReq,
    input  logic       IN_icFlushAck,
    output logic       OUT_tlbFlushReq,
    input  logic       IN_tlbFlushAck,
    output logic       OUT_disableIFetch,
    output logic       OUT_done,
    output logic       OUT_timeout
);
    typedef enum logic [2:0] {IDLE, DRAIN, ICFLUSH, TLBFLUSH, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] kind, kind_nx;
    logic [TIMEOUT_W-1:0] cnt, cnt_nx;
    logic drained, sat;
    assign drained = IN_sqEmpty && !IN_memBusy;
    assign sat = &cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            kind  <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            kind  <= kind_nx;
            cnt   <= cnt_nx;
        end
    end
    always_comb begin
        state_nx = state;
        kind_nx  = kind;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (IN_req) begin
                kind_nx  = IN_kind;
                cnt_nx   = '0;
                state_nx = DRAIN;
            end
            DRAIN:
                if (drained)
                    state_nx = kind == 2'd1 ? ICFLUSH : kind == 2'd2 ? TLBFLUSH : DONE;
                else if (sat)
                    state_nx = DONE;
                else
                    cnt_nx = cnt + 1'b1;
            ICFLUSH:  state_nx = IN_icFlushAck ? DONE : ICFLUSH;
            TLBFLUSH: state_nx = IN_tlbFlushAck ? DONE : TLBFLUSH;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    assign OUT_ready         = state == IDLE;
    assign OUT_disableIFetch = state == DRAIN || state == ICFLUSH || state == TLBFLUSH;
    assign OUT_icFlushReq    = state == ICFLUSH;
    assign OUT_tlbFlushReq   = state == TLBFLUSH;
    assign OUT_done          = state == DONE;
    // Pulses on the DRAIN exit cycle itself so it never overlaps the DONE pulse; a
    // reset in that cycle cancels the exit, so the pulse is suppressed too.
    assign OUT_timeout       = state == DRAIN && sat && !drained && !rst;
endmodule

// File: tb/tb_fence_sequencer.sv
module tb_fence_sequencer;
    localparam int W = 4;
    localparam int MAXC = (1 << W) - 1;
    logic clk = 0, rst = 1, req = 0, sq = 0, busy = 0, ic_ack = 0, tlb_ack = 0;
    logic [1:0] kind = 0;
    logic ready, ic_req, tlb_req, dis, done, tmo_o;
    int checks = 0, errors = 0;
    fence_sequencer #(.TIMEOUT_W(W)) dut (
        .clk(clk), .rst(rst), .IN_req(req), .IN_kind(kind), .OUT_ready(ready),
        .IN_sqEmpty(sq), .IN_memBusy(busy), .OUT_icFlushReq(ic_req), .IN_icFlushAck(ic_ack),
        .OUT_tlbFlushReq(tlb_req), .IN_tlbFlushAck(tlb_ack), .OUT_disableIFetch(dis),
        .OUT_done(done), .OUT_timeout(tmo_o)
    );
    always #5 clk = ~clk;

    task automatic check(input logic [5:0] exp, input string tag, input int c);
        logic [5:0] obs;
        #1;
        obs = {ready, dis, ic_req, tlb_req, done, tmo_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d got rdy/dis/ic/tlb/done/tmo=%b want %b", tag, c, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 0; kind = 2'($urandom); sq = 1'($urandom); busy = 1'($urandom);
            ic_ack = 1'($urandom); tlb_ack = 1'($urandom);
            check(6'b100000, "idle", i);
        end
    endtask

    // Timeline model: accept cycle, nd drain cycles, nf flush cycles, one done cycle.
    // Drain becomes true at drain index t; t beyond the saturating index means timeout.
    task automatic run_txn(input logic [1:0] k, input int t, input int d, input int rst_at, input string tag);
        int nd, nf, total;
        logic to;
        logic [5:0] e;
        to = t > MAXC;
        nd = to ? MAXC + 1 : t + 1;
        nf = (!to && (k == 2'd1 || k == 2'd2)) ? d + 1 : 0;
        total = 2 + nd + nf;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            req  = c == 0 ? 1'b1 : 1'($urandom);
            kind = c == 0 ? k : 2'($urandom);
            ic_ack = 1'($urandom); tlb_ack = 1'($urandom);
            if (c >= 1 && c <= nd) begin
                if (c - 1 >= t) begin
                    sq = 1; busy = 0;
                end else begin
                    case ($urandom % 3)
                        0: begin sq = 0; busy = 0; end
                        1: begin sq = 0; busy = 1; end
                        default: begin sq = 1; busy = 1; end
                    endcase
                end
            end else begin
                sq = 1'($urandom); busy = 1'($urandom);
            end
            if (c > nd && c <= nd + nf) begin
                if (k == 2'd1) ic_ack = (c - nd - 1) == d;
                else tlb_ack = (c - nd - 1) == d;
            end
            e = c == 0 ? 6'b100000 :
                c <= nd ? {5'b01000, to && c == nd} :
                c <= nd + nf ? {2'b01, k == 2'd1, k == 2'd2, 2'b00} : 6'b000010;
            if (c == rst_at) begin
                rst = 1;
                e[0] = 1'b0;
            end
            check(e, tag, c);
            if (c == rst_at) begin
                @(posedge clk);
                #1 rst = 0;
                return;
            end
        end
    endtask

    initial begin
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(6'b100000, "reset", 0);
        rst = 0;
        run_txn(2'd0, 0, 0, -1, "fence_fast");
        idle(1);
        run_txn(2'd1, 5, 3, -1, "fencei_drain5");
        run_txn(2'd2, 99, 0, -1, "sfence_timeout");
        run_txn(2'd2, MAXC, 2, -1, "drain_on_sat");
        run_txn(2'd1, MAXC + 1, 1, -1, "fencei_timeout");
        run_txn(2'd2, 0, 5, 3, "rst_in_tlbflush");
        idle(3);
        run_txn(2'd2, 20, 0, MAXC + 1, "rst_on_timeout");
        idle(2);
        run_txn(2'd1, 0, 0, -1, "b2b_fencei");
        run_txn(2'd2, 0, 0, -1, "b2b_sfence");
        run_txn(2'd3, 2, 0, -1, "reserved");
        for (int i = 0; i < 40; i++) begin
            run_txn(2'($urandom), $urandom_range(0, MAXC + 3), $urandom_range(0, 6), -1, "random");
            idle($urandom_range(0, 2));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
